mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
- REQ-001: Parameter DWELL, default 4, clock cycles spent on each select value (legal range 1..255).
- REQ-002: Parameter CONT_EN, default 0, enables continuous-scan support when 1.
- REQ-003: clk  input  1  single clock, all logic on rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: start  input  1  request one scan sweep, sampled only in IDLE.
- REQ-006: cont  input  1  continuous mode request; ignored when CONT_EN=0.
- REQ-007: y_in  input  1  Y output of the downstream 4:1 mux.
- REQ-008: sel  output  2  mux select, drives S of the 4:1 mux.
- REQ-009: sample  output  4  captured sweep result, bit i = Y with sel=i.
- REQ-010: busy  output  1  high whenever state is not IDLE.
- REQ-011: done  output  1  one-cycle pulse, sweep result published.

Function
- REQ-012: FSM states are IDLE, SCAN and DONE; encoding comes from the shared package.
- REQ-013: IDLE with start=1 moves to SCAN next cycle, with sel=0 and dwell count=0.
- REQ-014: In SCAN, the dwell count increments each cycle from 0 to DWELL-1, then wraps to 0 and sel increments.
- REQ-015: y_in is captured into shadow bit [sel] on the cycle where dwell count==DWELL-1 (settle of DWELL-1 cycles; no settle when DWELL=1).
- REQ-016: The capture at sel=3 with dwell count==DWELL-1 moves the FSM to DONE; sel wraps to 0.
- REQ-017: On entry to DONE, sample loads the full shadow register atomically; sample never shows a partial sweep.
- REQ-018: done=1 for exactly the one DONE cycle.
- REQ-019: DONE moves to SCAN if CONT_EN=1 and cont=1 (no gap cycle); otherwise it moves to IDLE.
- REQ-020: Start-to-done latency is 4*DWELL+1 cycles (start sampled at edge 0, done high after edge 4*DWELL+1).
- REQ-021: In continuous mode, done pulses every 4*DWELL+1 cycles.
- REQ-022: start is ignored while busy=1; there is no queuing.
- REQ-023: cont deasserting mid-sweep lets the current sweep complete, then the FSM returns to IDLE.
- REQ-024: sel is stable for the whole dwell window and changes only at the dwell wrap or on reset.
- REQ-025: sample holds its value in IDLE and SCAN until the next DONE.
- REQ-026: All outputs are registered; there is no combinational path from y_in to any output.

Reset
- REQ-027: rst=1 at a clock edge forces state=IDLE, sel=0, dwell count=0, shadow=0, sample=0, busy=0, done=0.
- REQ-028: rst asserted mid-sweep aborts the sweep with no done pulse, and sample is cleared to 0.
- REQ-029: rst has priority over start and cont in the same cycle.

Structure
- REQ-030: Shared package mux_scan_pkg holds the state typedef (IDLE/SCAN/DONE), N_CH=4 and SEL_W=2.
- REQ-031: The dwell counter is one sub-module, dwell_timer (parameter DWELL; ports clk, rst, en, clr, wrap).
- REQ-032: The FSM, sel counter, shadow register and sample register live in mux_scan_ctrl.

Verification
- REQ-033: The bench instantiates mux4x1 with sel->S and Y->y_in, DWELL=4.
- REQ-034: Single sweep: D0..D3 = 1,0,1,1 and start pulse -> sel steps 0,1,2,3 every 4 cycles; done after 17 cycles; sample=4'b1101.
- REQ-035: Continuous mode (CONT_EN=1, cont=1): D toggled between sweeps from 4'b0101 to 4'b1010 -> consecutive done pulses 17 cycles apart; sample 0101 then 1010.
- REQ-036: DWELL=1, D0..D3 = 0,1,1,0 -> done 5 cycles after start; sample=4'b0110; sel changes every cycle.
- REQ-037: start re-pulsed at cycle 6 of a sweep -> ignored; exactly one done; busy stays high for 17 cycles total.
- REQ-038: rst at cycle 9 of a sweep -> next cycle sel=0, busy=0, sample=0; no done pulse; a new start yields a normal sweep.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding and channel constants for the mux scan controller
package mux_scan_pkg;
   localparam int N_CH  = 4;
   localparam int SEL_W = 2;
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: counts dwell cycles per select value and flags the last one
module dwell_timer #(
   parameter int unsigned DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic wrap
);
   localparam logic [7:0] LAST = 8'(DWELL - 1);
   logic [7:0] cnt;
   // advance while enabled, restart at zero on clear or at the end of a dwell window
   always_ff @(posedge clk)
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= wrap ? '0 : cnt + 8'd1;
   assign wrap = en && (cnt == LAST);
endmodule

// File: rtl/mux4x1.sv
// mux4x1: plain 4:1 multiplexer, the scanned downstream device
module mux4x1 (
   input  logic [3:0] d,
   input  logic [1:0] s,
   output logic       y
);
   assign y = d[s];
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select through all inputs and publishes the captured sweep
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int unsigned DWELL   = 4,
   parameter bit          CONT_EN = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic             y_in,
   output logic [SEL_W-1:0] sel,
   output logic [N_CH-1:0]  sample,
   output logic             busy,
   output logic             done
);
   state_t          state, state_nx;
   logic            wrap, last_ch;
   logic [N_CH-1:0] shadow;

   dwell_timer #(.DWELL(DWELL)) u_dwell (
      .clk  (clk),
      .rst  (rst),
      .en   (state == SCAN),
      .clr  (state != SCAN),
      .wrap (wrap)
   );

   assign last_ch = sel == SEL_W'(N_CH - 1);
   assign busy    = state != IDLE;

   // next state: one sweep per start, chained sweeps only when continuous mode is built in and requested
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? SCAN : IDLE;
         SCAN:    state_nx = (wrap && last_ch) ? DONE : SCAN;
         DONE:    state_nx = (CONT_EN && cont) ? SCAN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nx;

   // at each dwell wrap latch the settled mux output and move to the next channel
   always_ff @(posedge clk)
      if (rst) begin
         sel    <= '0;
         shadow <= '0;
      end else if (wrap) begin
         sel         <= sel + SEL_W'(1);
         shadow[sel] <= y_in;
      end

   // publish the complete shadow word together with the done pulse
   always_ff @(posedge clk)
      if (rst) begin
         sample <= '0;
         done   <= 1'b0;
      end else begin
         done <= state == DONE;
         if (state == DONE) sample <= shadow;
      end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed checks of single, continuous, fast and aborted scan sweeps
module tb_mux_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       cont;
   logic       start_a [3];
   logic [3:0] d_a     [3];
   logic       y_a     [3];
   logic [1:0] sel_a   [3];
   logic [3:0] samp_a  [3];
   logic       busy_a  [3];
   logic       done_a  [3];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_scan_ctrl #(.DWELL(4), .CONT_EN(1'b0)) u0 (.clk(clk), .rst(rst), .start(start_a[0]), .cont(cont),
      .y_in(y_a[0]), .sel(sel_a[0]), .sample(samp_a[0]), .busy(busy_a[0]), .done(done_a[0]));
   mux_scan_ctrl #(.DWELL(4), .CONT_EN(1'b1)) u1 (.clk(clk), .rst(rst), .start(start_a[1]), .cont(cont),
      .y_in(y_a[1]), .sel(sel_a[1]), .sample(samp_a[1]), .busy(busy_a[1]), .done(done_a[1]));
   mux_scan_ctrl #(.DWELL(1), .CONT_EN(1'b0)) u2 (.clk(clk), .rst(rst), .start(start_a[2]), .cont(cont),
      .y_in(y_a[2]), .sel(sel_a[2]), .sample(samp_a[2]), .busy(busy_a[2]), .done(done_a[2]));
   mux4x1 m0 (.d(d_a[0]), .s(sel_a[0]), .y(y_a[0]));
   mux4x1 m1 (.d(d_a[1]), .s(sel_a[1]), .y(y_a[1]));
   mux4x1 m2 (.d(d_a[2]), .s(sel_a[2]), .y(y_a[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int k, output int n);
      n = 0;
      while (!done_a[k] && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic quiet(input int k, input string tag);
      int dn = 0;
      int bz = 0;
      repeat (20) begin
         tick();
         if (done_a[k]) dn++;
         if (busy_a[k]) bz++;
      end
      chk({tag, "_extra_done"}, dn, 0);
      chk({tag, "_extra_busy"}, bz, 0);
   endtask

   task automatic sweep(input int k, input int dw, input logic [3:0] exp_s, input int restart_at, input string tag);
      int n = 0;
      int bsy = 0;
      int bad = 0;
      start_a[k] = 1'b1;
      tick();
      start_a[k] = 1'b0;
      while (!done_a[k] && n < 200) begin
         if (n <= 4 * dw && sel_a[k] != 2'((n / dw) % 4)) bad++;
         if (busy_a[k]) bsy++;
         start_a[k] = n == restart_at;
         tick();
         n++;
      end
      start_a[k] = 1'b0;
      chk({tag, "_latency"}, n, 4 * dw + 1);
      chk({tag, "_sample"}, samp_a[k], exp_s);
      chk({tag, "_sel_steps"}, bad, 0);
      chk({tag, "_busy_cycles"}, bsy, 4 * dw + 1);
      chk({tag, "_busy_after"}, busy_a[k], 0);
      tick();
      chk({tag, "_done_width"}, done_a[k], 0);
      quiet(k, tag);
   endtask

   initial begin
      int n;
      rst  = 1'b1;
      cont = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_a[i] = 1'b0;
         d_a[i]     = 4'b0000;
      end
      repeat (2) tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst%0d_sel", i), sel_a[i], 0);
         chk($sformatf("rst%0d_sample", i), samp_a[i], 0);
         chk($sformatf("rst%0d_busy", i), busy_a[i], 0);
         chk($sformatf("rst%0d_done", i), done_a[i], 0);
      end
      rst = 1'b0;
      tick();

      d_a[0] = 4'b1101;
      sweep(0, 4, 4'b1101, -1, "single");

      cont   = 1'b1;
      d_a[0] = 4'b0110;
      sweep(0, 4, 4'b0110, 6, "restart");
      cont = 1'b0;

      d_a[2] = 4'b0110;
      sweep(2, 1, 4'b0110, -1, "dwell1");

      cont   = 1'b1;
      d_a[1] = 4'b0101;
      start_a[1] = 1'b1;
      tick();
      start_a[1] = 1'b0;
      wait_done(1, n);
      chk("cont_lat1", n, 17);
      chk("cont_sample1", samp_a[1], 4'b0101);
      chk("cont_busy_mid", busy_a[1], 1);
      d_a[1] = 4'b1010;
      repeat (5) tick();
      cont = 1'b0;
      wait_done(1, n);
      chk("cont_gap", n + 5, 17);
      chk("cont_sample2", samp_a[1], 4'b1010);
      chk("cont_busy_end", busy_a[1], 0);
      quiet(1, "cont");

      d_a[0] = 4'b1111;
      start_a[0] = 1'b1;
      tick();
      start_a[0] = 1'b0;
      repeat (9) tick();
      chk("abort_sel_before", sel_a[0], 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_sel", sel_a[0], 0);
      chk("abort_busy", busy_a[0], 0);
      chk("abort_sample", samp_a[0], 0);
      chk("abort_done", done_a[0], 0);
      quiet(0, "abort");

      rst        = 1'b1;
      start_a[0] = 1'b1;
      tick();
      rst        = 1'b0;
      start_a[0] = 1'b0;
      chk("rst_prio_busy", busy_a[0], 0);
      tick();
      chk("rst_prio_idle", busy_a[0], 0);

      d_a[0] = 4'b0011;
      sweep(0, 4, 4'b0011, -1, "after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
